// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the add/sub sequencing front end.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed extremes for a two's-complement word of w bits (w <= 32).
    function automatic logic [31:0] SMAX(input int unsigned w);
        SMAX = (32'h1 << (w - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] SMIN(input int unsigned w);
        SMIN = 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Request/result handshake bundle between a requester and the add/sub sequencer.
interface addsub_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic             in_acc;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;

    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/addsub_seq_ctrl_operand.sv
// Operand B preparation: negate for subtract and flag the MIN-negation corner.
module addsub_operand_prep
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_sign_i,
    output logic [WIDTH-1:0] add_b_o,
    output logic             min_neg_o,
    output logic             min_ovf_o
);
    localparam logic [WIDTH-1:0] MINV = WIDTH'(SMIN(WIDTH));

    always_comb begin
        add_b_o   = (op_i == OP_SUB) ? (~b_i + WIDTH'(1)) : b_i;
        min_neg_o = (op_i == OP_SUB) && (b_i == MINV);
        // -MIN wraps to MIN; A - MIN truly overflows exactly when A is non-negative.
        min_ovf_o = min_neg_o & ~a_sign_i;
    end
endmodule

// File: rtl/addsub_seq_ctrl.sv
// Add/sub sequencer: accepts requests, drives the external adder, captures,
// optionally saturates, and returns results; keeps accumulator and sticky overflow.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_seq_ctrl_if.slave     bus,
    input  logic                 acc_clr,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_ovf,
    output logic                 sticky_ovf,
    input  logic                 sticky_clr
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(SMAX(WIDTH));
    localparam logic [WIDTH-1:0] MINV = WIDTH'(SMIN(WIDTH));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, acc_q;
    logic             min_neg_q, min_ovf_q, ovf_q, sticky_q;

    logic             in_ready_c, out_valid_c;
    logic             accept, deliver;
    logic [WIDTH-1:0] acc_fwd, a_sel, b_prep, res_d;
    logic             min_neg, min_ovf, ovf_d;

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = EXEC;
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept  = bus.in_valid & in_ready_c;
    assign deliver = out_valid_c & bus.out_ready;

    // A request taken while a result is leaving must see that result as the accumulator.
    assign acc_fwd = acc_clr ? '0 : (deliver ? res_q : acc_q);
    assign a_sel   = bus.in_acc ? acc_fwd : bus.in_a;

    addsub_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .op_i      (bus.in_op),
        .b_i       (bus.in_b),
        .a_sign_i  (a_sel[WIDTH-1]),
        .add_b_o   (b_prep),
        .min_neg_o (min_neg),
        .min_ovf_o (min_ovf)
    );

    // On overflow the true result carries the sign of A.
    assign ovf_d = min_neg_q ? min_ovf_q : add_ovf;
    assign res_d = (SATURATE && ovf_d) ? (a_q[WIDTH-1] ? MINV : MAXV) : add_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            min_neg_q <= 1'b0;
            min_ovf_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= a_sel;
                b_q       <= b_prep;
                min_neg_q <= min_neg;
                min_ovf_q <= min_ovf;
            end
            if (state_q == EXEC) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
            acc_q    <= acc_fwd;
            sticky_q <= (deliver & ovf_q) | (sticky_q & ~sticky_clr);
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_result = res_q;
    assign bus.out_ovf    = ovf_q;
    assign add_a          = a_q;
    assign add_b          = b_q;
    assign sticky_ovf     = sticky_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl (SATURATE=1) with a per-cycle behavioural model.
module tb_addsub_seq_ctrl;
    localparam bit SAT = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_clr, sticky_clr, sticky_ovf, add_ovf;
    logic [15:0] add_a, add_b, add_sum;
    int          errors = 0;
    int          checks = 0;

    addsub_seq_ctrl_if #(.WIDTH(16)) bus ();

    addsub_seq_ctrl #(.WIDTH(16), .SATURATE(SAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .acc_clr    (acc_clr),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .add_ovf    (add_ovf),
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr)
    );

    // External combinational adder.
    assign add_sum = add_a + add_b;
    assign add_ovf = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of signed A op B as true integers, then clamp or wrap.
    function automatic logic [16:0] model_fn(input logic op, input logic [15:0] a, input logic [15:0] b);
        int   t;
        logic ov;
        logic [15:0] r;
        t  = op ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        ov = (t > 32767) || (t < -32768);
        r  = 16'(t);
        if (ov && SAT) r = (t > 0) ? 16'h7FFF : 16'h8000;
        return {ov, r};
    endfunction

    // Model: one request in flight, then one result held until taken.
    logic        m_live = 1'b0;
    logic        m_have, m_infl, m_ovf, m_iovf, m_sticky;
    logic [15:0] m_res, m_ires, m_ia, m_ib, m_acc;
    logic        m_dlv, m_take;
    logic [15:0] m_accn, m_opa;

    assign m_dlv  = m_have & bus.out_ready;
    assign m_take = bus.in_valid & !m_infl & (!m_have | bus.out_ready);
    assign m_accn = acc_clr ? 16'h0 : (m_dlv ? m_res : m_acc);
    assign m_opa  = bus.in_acc ? m_accn : bus.in_a;

    always @(posedge clk) begin
        if (rst) begin
            m_live   <= 1'b1;
            m_have   <= 1'b0;
            m_infl   <= 1'b0;
            m_acc    <= 16'h0;
            m_sticky <= 1'b0;
        end else if (m_live) begin
            m_acc    <= m_accn;
            m_sticky <= (m_dlv && m_ovf) ? 1'b1 : (sticky_clr ? 1'b0 : m_sticky);
            m_have   <= m_infl | (m_have & !m_dlv);
            if (m_infl) begin
                m_res <= m_ires;
                m_ovf <= m_iovf;
            end
            m_infl <= m_take;
            if (m_take) begin
                m_ia              <= m_opa;
                m_ib              <= bus.in_op ? 16'(16'h0 - bus.in_b) : bus.in_b;
                {m_iovf, m_ires}  <= model_fn(bus.in_op, m_opa, bus.in_b);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("m_out_valid", 32'(bus.out_valid), 32'(m_have));
            check("m_in_ready", 32'(bus.in_ready), 32'(!m_infl && (!m_have || bus.out_ready)));
            check("m_sticky", 32'(sticky_ovf), 32'(m_sticky));
            if (m_have) begin
                check("m_result", 32'(bus.out_result), 32'(m_res));
                check("m_ovf", 32'(bus.out_ovf), 32'(m_ovf));
            end
            if (m_infl) begin
                check("m_add_a", 32'(add_a), 32'(m_ia));
                check("m_add_b", 32'(add_b), 32'(m_ib));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic ac, input logic clr,
                        input logic [15:0] a, input logic [15:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_acc = ac;
        bus.in_a = a; bus.in_b = b; acc_clr = clr;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus.in_ready) ok = 1'b1;
            step();
        end
        bus.in_valid = 1'b0; acc_clr = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never seen, required 1");
        end
    endtask

    task automatic wait_res(input string nm, input logic [15:0] er, input logic eo);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus.out_valid) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid never seen, required 1", nm);
        end else begin
            check({nm, "_res"}, 32'(bus.out_result), 32'(er));
            check({nm, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
        end
    endtask

    initial begin
        rst = 1'b1; acc_clr = 1'b0; sticky_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_acc = 1'b0;
        bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_result", 32'(bus.out_result), 32'h0);
        check("rst_sticky", 32'(sticky_ovf), 32'h0);
        check("rst_add_ab", {add_a, add_b}, 32'h0);
        rst = 1'b0;
        step();

        // Plain add and latency
        send(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0F0F);
        check("t1_exec_valid", 32'(bus.out_valid), 32'h0);
        step();
        check("t1_hold_valid", 32'(bus.out_valid), 32'h1);
        wait_res("t1", 16'h2143, 1'b0);
        step();

        // Subtract, including negation of MIN
        send(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0007);
        wait_res("t2a", 16'hFFFE, 1'b0);
        step();
        send(1'b1, 1'b0, 1'b0, 16'h0000, 16'h8000);
        wait_res("t2b", 16'h7FFF, 1'b1);
        step();
        check("t2_sticky", 32'(sticky_ovf), 32'h1);
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        check("t2_sticky_clr", 32'(sticky_ovf), 32'h0);

        // Positive and negative saturation, clear/set collision
        send(1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
        wait_res("t3a", 16'h7FFF, 1'b1);
        step();
        check("t3_sticky", 32'(sticky_ovf), 32'h1);
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        check("t3_sticky_clr", 32'(sticky_ovf), 32'h0);
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 16'h8000, 16'hFFFF);
        wait_res("t3b", 16'h8000, 1'b1);
        sticky_clr = 1'b1; bus.out_ready = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("t3_set_wins", 32'(sticky_ovf), 32'h1);

        // Backpressure then back-to-back accept
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0022);
        wait_res("t4a", 16'h0122, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(bus.out_valid), 32'h1);
            check("t4_hold_res", 32'(bus.out_result), 32'h0122);
            check("t4_hold_in_ready", 32'(bus.in_ready), 32'h0);
            step();
        end
        bus.in_valid = 1'b1; bus.in_op = 1'b0; bus.in_acc = 1'b0;
        bus.in_a = 16'h0001; bus.in_b = 16'h0002; bus.out_ready = 1'b1;
        #1;
        check("t4_in_ready_comb", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        check("t4_exec_valid", 32'(bus.out_valid), 32'h0);
        step();
        wait_res("t4b", 16'h0003, 1'b0);
        step();

        // Accumulate with forwarding, clear on the accepting cycle
        acc_clr = 1'b1; step(); acc_clr = 1'b0;
        send(1'b0, 1'b1, 1'b0, 16'h5555, 16'h0100);
        wait_res("t5a", 16'h0100, 1'b0);
        send(1'b0, 1'b1, 1'b0, 16'h5555, 16'h0100);
        wait_res("t5b", 16'h0200, 1'b0);
        send(1'b0, 1'b1, 1'b0, 16'h5555, 16'h0100);
        wait_res("t5c", 16'h0300, 1'b0);
        send(1'b0, 1'b1, 1'b1, 16'h5555, 16'h0100);
        wait_res("t5d", 16'h0100, 1'b0);
        step();

        // Reset while holding a result
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001);
        wait_res("t6a", 16'h0002, 1'b0);
        check("t6_sticky_pre", 32'(sticky_ovf), 32'h1);
        rst = 1'b1;
        step();
        check("t6_out_valid", 32'(bus.out_valid), 32'h0);
        check("t6_in_ready", 32'(bus.in_ready), 32'h1);
        check("t6_sticky", 32'(sticky_ovf), 32'h0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        send(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0005);
        wait_res("t6_acc_zero", 16'h0005, 1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
